// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD, DONE} state_e;
  typedef enum logic {PORT_A, PORT_B} port_e;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker; bit 0 = port A, bit 1 = port B. Combinational.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_e      ptr,
  input  logic       fixed,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    // Only a tie needs a decision; fixed mode always favours B.
    if (req == 2'b11) grant = (fixed || ptr == PORT_B) ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for a shared single-port memory: fixed 2-cycle access window, 1-cycle ack.
// Build option ARB_FIXED_PRIO_EN: port B always wins ties instead of round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_ls,
  output logic [AW-1:0] mem_add,
  inout  wire  [DW-1:0] mem_data
);

`ifdef ARB_FIXED_PRIO_EN
  localparam logic FIXED_PRIO = 1'b1;
`else
  localparam logic FIXED_PRIO = 1'b0;
`endif

  state_e          state_q, state_d;
  port_e           gnt_q, ptr_q;
  logic [AW-1:0]   addr_q;
  logic            we_q;
  logic [DW-1:0]   wdata_q;
  logic            a_ack_q, b_ack_q;
  logic [DW-1:0]   a_rdata_q, b_rdata_q;
  logic [1:0]      grant;
  logic            in_win;

  arb_rr2 u_pick (
    .req   ({b_req, a_req}),
    .ptr   (ptr_q),
    .fixed (FIXED_PRIO),
    .grant (grant)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (a_req || b_req) state_d = ACCESS;
      ACCESS:  state_d = HOLD;
      HOLD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= PORT_A;
      ptr_q     <= PORT_A;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && (a_req || b_req)) begin
        gnt_q   <= grant[1] ? PORT_B : PORT_A;
        addr_q  <= grant[1] ? b_addr : a_addr;
        we_q    <= grant[1] & b_we;
        wdata_q <= b_wdata;
      end
      // Ack lands in DONE; load data is taken off the bus on the same edge.
      a_ack_q <= (state_q == HOLD) && (gnt_q == PORT_A);
      b_ack_q <= (state_q == HOLD) && (gnt_q == PORT_B);
      if (state_q == HOLD && !we_q) begin
        if (gnt_q == PORT_A) a_rdata_q <= mem_data;
        else                 b_rdata_q <= mem_data;
      end
      if (state_q == DONE) ptr_q <= other_port(gnt_q);
    end
  end

  assign in_win   = (state_q == ACCESS) || (state_q == HOLD);
  assign mem_en   = in_win;
  assign mem_ls   = in_win ? ~we_q : 1'b1;
  assign mem_add  = in_win ? addr_q : '0;
  assign mem_data = (in_win && we_q) ? wdata_q : {DW{1'bz}};

  assign busy    = (state_q != IDLE);
  assign a_ack   = a_ack_q;
  assign b_ack   = b_ack_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of transactions plus alternation and mid-access reset sequences.
module tb_mem_arbiter;

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [7:0]  a_addr = '0, b_addr = '0;
  logic [15:0] b_wdata = '0;
  logic        a_ack, b_ack, busy, mem_en, mem_ls;
  logic [15:0] a_rdata, b_rdata;
  logic [7:0]  mem_add;
  wire  [15:0] mem_data;

  logic [15:0] mem [256];
  logic        init_mem = 1'b1;

  int checks = 0;
  int errors = 0;
  logic [15:0] last_a = '0, last_b = '0;

  typedef struct {
    logic        a_req;
    logic [7:0]  a_addr;
    logic        b_req;
    logic        b_we;
    logic [7:0]  b_addr;
    logic [15:0] b_wdata;
    logic        b_first;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs [8];

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .busy(busy),
    .mem_en(mem_en), .mem_ls(mem_ls), .mem_add(mem_add), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // Memory model: asynchronous read during load windows, write on the clock during store windows.
  assign mem_data = (mem_en && mem_ls) ? mem[mem_add] : 16'hzzzz;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(i);
    end else if (mem_en && !mem_ls) begin
      mem[mem_add] <= mem_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_released(input string nm, input logic [15:0] drv);
    checks++;
    if (mem_data === drv) begin
      errors++;
      $display("FAIL %s bus still shows %h, want released", nm, drv);
    end
  endtask

  function automatic vec_t mk(input logic ar, input logic [7:0] aa, input logic br, input logic bw,
                              input logic [7:0] ba, input logic [15:0] bd, input logic bf,
                              input logic [15:0] ea, input logic [15:0] eb);
    vec_t v;
    v.a_req = ar; v.a_addr = aa; v.b_req = br; v.b_we = bw; v.b_addr = ba;
    v.b_wdata = bd; v.b_first = bf; v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  // Applies one vector and checks a fixed 12-cycle window cycle by cycle.
  task automatic run_vec(input int id, input vec_t v);
    logic both, fp, sp, act, port, exp_en, exp_ls, exp_aa, exp_ba, exp_busy;
    logic [7:0] exp_add;
    both = v.a_req && v.b_req;
    fp   = both ? v.b_first : v.b_req;
    sp   = ~fp;
    @(negedge clk);
    a_req = v.a_req; a_addr = v.a_addr;
    b_req = v.b_req; b_we = v.b_we; b_addr = v.b_addr; b_wdata = v.b_wdata;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      act  = 1'b0;
      port = fp;
      if (c == 1 || c == 2) act = 1'b1;
      if (both && (c == 5 || c == 6)) begin act = 1'b1; port = sp; end
      exp_en  = act;
      exp_ls  = act ? (port ? ~v.b_we : 1'b1) : 1'b1;
      exp_add = port ? v.b_addr : v.a_addr;
      exp_aa  = (c == 3 && fp == 1'b0) || (both && c == 7 && sp == 1'b0);
      exp_ba  = (c == 3 && fp == 1'b1) || (both && c == 7 && sp == 1'b1);
      exp_busy = (c >= 1 && c <= 3) || (both && c >= 5 && c <= 7);
      chk($sformatf("v%0d c%0d mem_en", id, c), 32'(mem_en), 32'(exp_en));
      chk($sformatf("v%0d c%0d mem_ls", id, c), 32'(mem_ls), 32'(exp_ls));
      if (exp_en) chk($sformatf("v%0d c%0d mem_add", id, c), 32'(mem_add), 32'(exp_add));
      chk($sformatf("v%0d c%0d busy", id, c), 32'(busy), 32'(exp_busy));
      chk($sformatf("v%0d c%0d a_ack", id, c), 32'(a_ack), 32'(exp_aa));
      chk($sformatf("v%0d c%0d b_ack", id, c), 32'(b_ack), 32'(exp_ba));
      if (act && port && v.b_we && c != 1 && c != 5)
        chk($sformatf("v%0d c%0d store bus", id, c), 32'(mem_data), 32'(v.b_wdata));
      if (v.b_req && v.b_we && exp_ba)
        chk_released($sformatf("v%0d c%0d done bus", id, c), v.b_wdata);
      if (a_ack) begin
        chk($sformatf("v%0d a_rdata", id), 32'(a_rdata), 32'(v.exp_a));
        a_req = 1'b0;
      end
      if (b_ack) begin
        if (!v.b_we) chk($sformatf("v%0d b_rdata", id), 32'(b_rdata), 32'(v.exp_b));
        b_req = 1'b0;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    if (v.a_req) last_a = v.exp_a;
    if (v.b_req && !v.b_we) last_b = v.exp_b;
    chk($sformatf("v%0d a_rdata hold", id), 32'(a_rdata), 32'(last_a));
    chk($sformatf("v%0d b_rdata hold", id), 32'(b_rdata), 32'(last_b));
  endtask

  initial begin
    int n, lastc;
    logic lastp, p, expp;

    vecs[0] = mk(1, 8'h01, 1, 0, 8'h02, 16'h0000, FIXED, 16'h0001, 16'h0002);
    vecs[1] = mk(1, 8'h05, 0, 0, 8'h00, 16'h0000, 0,     16'h0005, 16'h0000);
    vecs[2] = mk(0, 8'h00, 1, 1, 8'h10, 16'hBEEF, 1,     16'h0000, 16'h0000);
    vecs[3] = mk(1, 8'h10, 0, 0, 8'h00, 16'h0000, 0,     16'hBEEF, 16'h0000);
    vecs[4] = mk(0, 8'h00, 1, 0, 8'hFF, 16'h0000, 1,     16'h0000, 16'h00FF);
    vecs[5] = mk(1, 8'h10, 1, 0, 8'h05, 16'h0000, FIXED, 16'hBEEF, 16'h0005);
    vecs[6] = mk(1, 8'h03, 1, 1, 8'h30, 16'h1234, FIXED, 16'h0003, 16'h0000);
    vecs[7] = mk(1, 8'h30, 0, 0, 8'h00, 16'h0000, 0,     16'h1234, 16'h0000);

    repeat (3) @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst mem_en", 32'(mem_en), 32'd0);
    chk("rst mem_ls", 32'(mem_ls), 32'd1);
    chk("rst mem_add", 32'(mem_add), 32'd0);
    chk("rst acks", {30'd0, a_ack, b_ack}, 32'd0);
    chk("rst a_rdata", 32'(a_rdata), 32'd0);
    chk("rst b_rdata", 32'(b_rdata), 32'd0);
    rst_n = 1'b1;
    init_mem = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Both ports hold requests across six accesses.
    @(negedge clk);
    a_req = 1'b1; a_addr = 8'h07;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h08;
    n = 0; lastc = 0; lastp = 1'b0;
    for (int c = 1; c <= 40 && n < 6; c++) begin
      @(negedge clk);
      if (a_ack || b_ack) begin
        chk($sformatf("alt%0d single ack", n), 32'(a_ack && b_ack), 32'd0);
        p = b_ack;
        expp = FIXED ? 1'b1 : ~n[0];
        chk($sformatf("alt%0d port", n), 32'(p), 32'(expp));
        if (n > 0) begin
          chk($sformatf("alt%0d spacing", n), 32'(c - lastc), 32'd4);
          if (!FIXED) chk($sformatf("alt%0d not repeat", n), 32'(p == lastp), 32'd0);
        end
        if (p) chk($sformatf("alt%0d b_rdata", n), 32'(b_rdata), 32'h0008);
        else   chk($sformatf("alt%0d a_rdata", n), 32'(a_rdata), 32'h0007);
        lastc = c; lastp = p; n++;
        if (n == 6) begin a_req = 1'b0; b_req = 1'b0; end
      end
    end
    chk("alt ack count", 32'(n), 32'd6);
    a_req = 1'b0; b_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("alt idle busy", 32'(busy), 32'd0);

    // Reset during the HOLD cycle of a store.
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h20; b_wdata = 16'h5A5A;
    @(negedge clk);
    @(negedge clk);
    chk("mid hold bus", 32'(mem_data), 32'h5A5A);
    chk("mid hold ls", 32'(mem_ls), 32'd0);
    rst_n = 1'b0;
    b_req = 1'b0;
    #1;
    chk("mid rst mem_en", 32'(mem_en), 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst mem_ls", 32'(mem_ls), 32'd1);
    chk("mid rst mem_add", 32'(mem_add), 32'd0);
    chk("mid rst b_ack", 32'(b_ack), 32'd0);
    chk_released("mid rst bus", 16'h5A5A);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_a = '0; last_b = '0;
    chk("post rst a_rdata", 32'(a_rdata), 32'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("post rst c%0d acks", c), {30'd0, a_ack, b_ack}, 32'd0);
    end
    run_vec(8, mk(1, 8'h01, 1, 0, 8'h02, 16'h0000, FIXED, 16'h0001, 16'h0002));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
